// File: rtl/db_dram_arb.sv
// db_dram_arb: round-robin sharing of the DRAM command port between the hash-table and data-store paths, with read-credit limiting and in-order return routing.
module db_dram_arb #(
  parameter int RAM_ADDR   = 22,
  parameter int RAM_DWIDTH = 32,
  parameter int MAX_OUTST  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req0_valid,
  input  logic                         req0_we,
  input  logic [RAM_ADDR-1:0]          req0_addr,
  input  logic [RAM_DWIDTH-1:0]        req0_wdata,
  output logic                         req0_ready,
  input  logic                         req1_valid,
  input  logic                         req1_we,
  input  logic [RAM_ADDR-1:0]          req1_addr,
  input  logic [RAM_DWIDTH-1:0]        req1_wdata,
  output logic                         req1_ready,
  output logic                         rsp0_valid,
  output logic [RAM_DWIDTH-1:0]        rsp0_data,
  output logic                         rsp1_valid,
  output logic [RAM_DWIDTH-1:0]        rsp1_data,
  output logic                         dram_wr_en,
  output logic                         dram_rd_en,
  output logic [RAM_ADDR-1:0]          dram_addr,
  output logic [RAM_DWIDTH-1:0]        dram_wr_din,
  input  logic [RAM_DWIDTH-1:0]        dram_rd_dout,
  input  logic                         dram_rd_valid,
  output logic [$clog2(MAX_OUTST):0]   outst_cnt,
  output logic                         err_unexp
);
  localparam int CW = $clog2(MAX_OUTST) + 1;
  localparam int AW = $clog2(MAX_OUTST);
  localparam logic [CW-1:0] FULL = CW'(MAX_OUTST);
  logic          last, el0, el1, g1, acc, we, rd_iss, pop, rid;
  logic [AW-1:0] wp, rp;
  logic          id_mem [MAX_OUTST];
  always_comb begin
    el0        = rst && req0_valid && (req0_we || outst_cnt < FULL);
    el1        = rst && req1_valid && (req1_we || outst_cnt < FULL);
    req0_ready = el0 && (!el1 || last);
    req1_ready = el1 && (!el0 || !last);
    acc        = req0_ready || req1_ready;
    g1         = req1_ready;
    we         = g1 ? req1_we : req0_we;
    rd_iss     = acc && !we;
    pop        = dram_rd_valid && outst_cnt != '0;
    rid        = id_mem[rp];
  end
  // ID memory needs no reset: entries are only read behind the write pointer.
  always_ff @(posedge clk)
    if (rd_iss) id_mem[wp] <= g1;
  always_ff @(posedge clk) begin
    if (!rst) begin
      last        <= 1'b1;
      dram_wr_en  <= 1'b0;
      dram_rd_en  <= 1'b0;
      dram_addr   <= '0;
      dram_wr_din <= '0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp0_data   <= '0;
      rsp1_data   <= '0;
      wp          <= '0;
      rp          <= '0;
      outst_cnt   <= '0;
      err_unexp   <= 1'b0;
    end else begin
      dram_wr_en <= acc && we;
      dram_rd_en <= rd_iss;
      if (acc) begin
        last        <= g1;
        dram_addr   <= g1 ? req1_addr : req0_addr;
        dram_wr_din <= we ? (g1 ? req1_wdata : req0_wdata) : '0;
      end
      rsp0_valid <= pop && !rid;
      rsp1_valid <= pop && rid;
      if (pop && !rid) rsp0_data <= dram_rd_dout;
      if (pop && rid) rsp1_data <= dram_rd_dout;
      if (rd_iss) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      outst_cnt <= outst_cnt + CW'(rd_iss) - CW'(pop);
      err_unexp <= err_unexp | (dram_rd_valid && outst_cnt == '0);
    end
  end
endmodule

// File: doc/db_dram_arb.md
# db_dram_arb

Shares the single DRAM command port of the key-value store between two requesters: the hash-table (key lookup) path, requester 0, and the data-store (value lookup/update) path, requester 1. Round-robin arbitration on a valid/ready handshake issues one registered command per cycle and bounds outstanding reads with a credit counter. A requester-ID FIFO routes each in-order `dram_rd_valid` return back to the requester that issued the read. Sits between `db_cont`'s lookup logic and the DRAM controller.

## Interface
- `RAM_ADDR`, 22, DRAM word address width
- `RAM_DWIDTH`, 32, DRAM data width
- `MAX_OUTST`, 8, max outstanding reads; power of two, 2..64
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-low reset
- `req0_valid` / `req1_valid`  in  1  command request
- `req0_we` / `req1_we`  in  1  1 = write, 0 = read
- `req0_addr` / `req1_addr`  in  RAM_ADDR  word address
- `req0_wdata` / `req1_wdata`  in  RAM_DWIDTH  write data; ignored for reads
- `req0_ready` / `req1_ready`  out  1  grant; command accepted when valid && ready
- `rsp0_valid` / `rsp1_valid`  out  1  read return strobe, one cycle per word
- `rsp0_data` / `rsp1_data`  out  RAM_DWIDTH  read return data
- `dram_wr_en`  out  1  write strobe
- `dram_rd_en`  out  1  read strobe
- `dram_addr`  out  RAM_ADDR  command address
- `dram_wr_din`  out  RAM_DWIDTH  write data
- `dram_rd_dout`  in  RAM_DWIDTH  read data
- `dram_rd_valid`  in  1  read data valid; returns are in issue order
- `outst_cnt`  out  $clog2(MAX_OUTST)+1  reads in flight
- `err_unexp`  out  1  sticky: `dram_rd_valid` arrived with no read outstanding

## Operation
- Eligibility: requester i is eligible when `reqi_valid && (reqi_we || outst_cnt < MAX_OUTST)`. A read without credit does not block the other requester.
- Arbitration: 1-bit `last` pointer. Both eligible -> grant the requester that is not `last`. One eligible -> grant it. Update `last` only on a grant. At most one `ready` high per cycle.
- `reqi_ready` is combinational from eligibility and `last`. It may depend on `reqi_valid`; requesters must not make `valid` depend on `ready`.
- Issue: on acceptance, register `dram_addr`, `dram_wr_din`, and `dram_wr_en = we` or `dram_rd_en = !we`. Strobes are high for exactly one cycle. `dram_addr`/`dram_wr_din` hold their last value when idle. `dram_wr_din` is 0 for reads.
- Read issue pushes the requester ID into the ID FIFO (depth MAX_OUTST, width 1) and increments `outst_cnt`.
- Return: on `dram_rd_valid` with FIFO non-empty, pop the ID and decrement `outst_cnt`. Next cycle, drive `rspID_valid = 1` and `rspID_data = dram_rd_dout` (registered). The other `rsp` valid stays 0. `rsp*_data` holds when idle.
- Read issue and return in the same cycle: `outst_cnt` is unchanged; FIFO push and pop both occur.
- Return with FIFO empty: drop the word, set `err_unexp`. Counter stays 0, no `rsp` pulse. `err_unexp` clears only on reset.
- Credit check uses the registered `outst_cnt`. A return in the same cycle does not free a credit until the next cycle.

## Timing
- Reset (`rst == 0` at an edge) drives these values:
  - `dram_wr_en`, `dram_rd_en`, `rsp*_valid`, `err_unexp` = 0
  - `dram_addr`, `dram_wr_din`, `rsp*_data` = 0
  - `outst_cnt` = 0, ID FIFO empty
  - `last` = 1, so requester 0 wins the first tie
- `req*_ready` is 0 while `rst == 0`.
- Reset mid-operation discards in-flight reads. Returns arriving after reset set `err_unexp`.
- Acceptance at edge N -> DRAM strobe high during cycle N+1.
- `dram_rd_valid` at edge M -> `rsp` valid during cycle M+1.
- Throughput: one command per cycle. A single continuously valid requester is granted every cycle. Two contending requesters alternate strictly.
- `outst_cnt` saturates at MAX_OUTST by construction; a read is never issued at MAX_OUTST.

## Test plan
- Reset, then req0 read addr 0x000010 alone -> `req0_ready` = 1 same cycle; `dram_rd_en` = 1 and `dram_addr` = 0x000010 next cycle; `outst_cnt` = 1. Return 0xDEADBEEF -> `rsp0_valid` with 0xDEADBEEF one cycle later, `outst_cnt` = 0.
- Both requesters hold valid reads for 6 cycles from reset -> grants alternate 0,1,0,1,0,1. Returns A..F are delivered to rsp0,rsp1,rsp0,rsp1,rsp0,rsp1 in order.
- req0 issues 8 reads with no returns -> `outst_cnt` = 8 and `req0_ready` = 0. req1 write addr 0x3FFFFF data 0x12345678 still granted -> `dram_wr_en` pulse. One return -> req0 ready again the following cycle.
- At `outst_cnt` = 3, a read issue and `dram_rd_valid` in the same cycle -> `outst_cnt` stays 3. Return routed to the oldest ID.
- `dram_rd_valid` with nothing outstanding -> no `rsp` pulse, `err_unexp` = 1 and stays high until `rst` low.
- `rst` low for one cycle with 4 reads outstanding -> all outputs at reset values and `outst_cnt` = 0. A late return sets `err_unexp`.
